// File: rtl/pwm_pkg.sv
// Shared encodings for the multi-channel PWM block: counting mode and counter direction.
package pwm_pkg;

   typedef enum logic {
      MODE_EDGE   = 1'b0,
      MODE_CENTER = 1'b1
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

endpackage

// File: rtl/pwm_dead_band.sv
// One channel's output stage: registers the raw compare result and drives a complementary
// pos/neg pair, blanking both outputs for dead_i cycles around every raw transition.
module pwm_dead_band
   import pwm_pkg::*;
#(
   parameter int DT_W = 8
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            en_i,
   input  logic            raw_i,
   input  logic [DT_W-1:0] dead_i,
   output logic            pos_o,
   output logic            neg_o
);

   logic            raw_q;
   logic [DT_W-1:0] dcnt_q;
   logic            pos_q;
   logic            neg_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         raw_q  <= 1'b0;
         dcnt_q <= '0;
         pos_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else if (!en_i) begin
         raw_q  <= 1'b0;
         dcnt_q <= '0;
         pos_q  <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         raw_q <= raw_i;
         // A raw edge (re)starts the gap; dcnt_q==1 is the last blanked cycle.
         if ((raw_i != raw_q) && (dead_i != '0)) begin
            dcnt_q <= dead_i;
            pos_q  <= 1'b0;
            neg_q  <= 1'b0;
         end else if ((raw_i == raw_q) && (dcnt_q > DT_W'(1))) begin
            dcnt_q <= dcnt_q - DT_W'(1);
            pos_q  <= 1'b0;
            neg_q  <= 1'b0;
         end else begin
            dcnt_q <= '0;
            pos_q  <= raw_i;
            neg_q  <= ~raw_i;
         end
      end
   end

   assign pos_o = pos_q;
   assign neg_o = neg_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaled edge/center counter, shadowed period parameters
// and per-channel complementary outputs with dead-time insertion.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int CNT_LENGTH = 16,
   parameter int NUM_CH     = 4,
   parameter int PSC_W      = 8,
   parameter int DT_W       = 8
) (
   input  logic                         sys_clk,
   input  logic                         sys_rst_n,
   input  logic                         sys_en,
   input  logic                         center_mode,
   input  logic [PSC_W-1:0]             prescale,
   input  logic [CNT_LENGTH-1:0]        max_val,
   input  logic [NUM_CH*CNT_LENGTH-1:0] duty_cycle,
   input  logic [DT_W-1:0]              dead_time,
   output logic [NUM_CH-1:0]            pwm_pos,
   output logic [NUM_CH-1:0]            pwm_neg,
   output logic [CNT_LENGTH-1:0]        cnt_out,
   output logic                         period_done
);

   logic [PSC_W-1:0]             psc_q, psc_d;
   logic [CNT_LENGTH-1:0]        cnt_q, cnt_d;
   dir_e                         dir_q, dir_d;
   mode_e                        mode_sh_q;
   logic [CNT_LENGTH-1:0]        max_sh_q;
   logic [NUM_CH*CNT_LENGTH-1:0] duty_sh_q;
   logic [DT_W-1:0]              dead_sh_q;
   logic                         period_done_q;
   logic                         tick;
   logic                         update;
   logic [NUM_CH-1:0]            raw;

   assign tick = (psc_q >= prescale);

   always_comb begin
      psc_d  = tick ? '0 : psc_q + PSC_W'(1);
      cnt_d  = cnt_q;
      dir_d  = dir_q;
      update = 1'b0;
      if (tick) begin
         if (mode_sh_q == MODE_EDGE) begin
            dir_d = DIR_UP;
            if (cnt_q == max_sh_q) update = 1'b1;
            else                   cnt_d  = cnt_q + CNT_LENGTH'(1);
         end else if ((max_sh_q == '0) || ((dir_q == DIR_DOWN) && (cnt_q == CNT_LENGTH'(1)))) begin
            update = 1'b1;
         end else if (dir_q == DIR_UP) begin
            // Direction flips as the peak is reached so the peak is counted once.
            cnt_d = cnt_q + CNT_LENGTH'(1);
            if (cnt_d == max_sh_q) dir_d = DIR_DOWN;
         end else begin
            cnt_d = cnt_q - CNT_LENGTH'(1);
         end
         if (update) begin
            cnt_d = '0;
            dir_d = DIR_UP;
         end
      end
   end

   // period_done: single-cycle strobe with no back-pressure; it is high in the first
   // cycle in which the newly loaded shadow values are in effect.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         psc_q         <= '0;
         cnt_q         <= '0;
         dir_q         <= DIR_UP;
         period_done_q <= 1'b0;
         mode_sh_q     <= MODE_EDGE;
         max_sh_q      <= '0;
         duty_sh_q     <= '0;
         dead_sh_q     <= '0;
      end else if (!sys_en) begin
         psc_q         <= '0;
         cnt_q         <= '0;
         dir_q         <= DIR_UP;
         period_done_q <= 1'b0;
         mode_sh_q     <= mode_e'(center_mode);
         max_sh_q      <= max_val;
         duty_sh_q     <= duty_cycle;
         dead_sh_q     <= dead_time;
      end else begin
         psc_q         <= psc_d;
         cnt_q         <= cnt_d;
         dir_q         <= dir_d;
         period_done_q <= update;
         if (update) begin
            mode_sh_q <= mode_e'(center_mode);
            max_sh_q  <= max_val;
            duty_sh_q <= duty_cycle;
            dead_sh_q <= dead_time;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      assign raw[i] = (cnt_q >= duty_sh_q[i*CNT_LENGTH +: CNT_LENGTH]);

      pwm_dead_band #(
         .DT_W (DT_W)
      ) u_dead_band (
         .clk_i  (sys_clk),
         .rst_ni (sys_rst_n),
         .en_i   (sys_en),
         .raw_i  (raw[i]),
         .dead_i (dead_sh_q),
         .pos_o  (pwm_pos[i]),
         .neg_o  (pwm_neg[i])
      );
   end

   assign cnt_out     = cnt_q;
   assign period_done = period_done_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: period-position reference model feeding an expected queue,
// a negedge monitor that pops and compares, plus directed window counts.
module tb_pwm_multi;

   localparam int CNT_LENGTH = 16;
   localparam int NUM_CH     = 4;
   localparam int PSC_W      = 8;
   localparam int DT_W       = 8;
   localparam int EW         = 1 + 2*NUM_CH + CNT_LENGTH;

   logic                         sys_clk     = 1'b0;
   logic                         sys_rst_n   = 1'b0;
   logic                         sys_en      = 1'b0;
   logic                         center_mode = 1'b0;
   logic [PSC_W-1:0]             prescale    = '0;
   logic [CNT_LENGTH-1:0]        max_val     = '0;
   logic [NUM_CH*CNT_LENGTH-1:0] duty_cycle  = '0;
   logic [DT_W-1:0]              dead_time   = '0;
   logic [NUM_CH-1:0]            pwm_pos;
   logic [NUM_CH-1:0]            pwm_neg;
   logic [CNT_LENGTH-1:0]        cnt_out;
   logic                         period_done;

   int n_checks = 0;
   int n_errors = 0;
   int duty_v[NUM_CH];

   logic [EW-1:0] exp_q[$];

   pwm_multi #(
      .CNT_LENGTH (CNT_LENGTH),
      .NUM_CH     (NUM_CH),
      .PSC_W      (PSC_W),
      .DT_W       (DT_W)
   ) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .sys_en      (sys_en),
      .center_mode (center_mode),
      .prescale    (prescale),
      .max_val     (max_val),
      .duty_cycle  (duty_cycle),
      .dead_time   (dead_time),
      .pwm_pos     (pwm_pos),
      .pwm_neg     (pwm_neg),
      .cnt_out     (cnt_out),
      .period_done (period_done)
   );

   // ---------------- clock ----------------
   always #5 sys_clk = ~sys_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Tracks position p inside the current period; cnt is derived from p and the shadows.
   int            m_p, m_k, m_cyc, m_cnt;
   int            m_max, m_center, m_dead;
   int            m_duty[NUM_CH];
   int            m_raw[NUM_CH];
   int            m_rawq[NUM_CH];
   int            m_chg_cyc[NUM_CH];
   int            m_chg_d[NUM_CH];
   logic          m_done;
   logic [NUM_CH-1:0] m_pos_e, m_neg_e;

   function automatic int period_len(input int mx, input int ctr);
      if (mx == 0) return 1;
      return (ctr != 0) ? 2*mx : mx + 1;
   endfunction

   function automatic int cnt_at(input int p, input int mx, input int ctr);
      if (mx == 0) return 0;
      if (ctr == 0) return p;
      return (p <= mx) ? p : 2*mx - p;
   endfunction

   task automatic load_shadows();
      m_max    = int'(max_val);
      m_center = int'(center_mode);
      m_dead   = int'(dead_time);
      for (int i = 0; i < NUM_CH; i++) m_duty[i] = int'(duty_cycle[i*CNT_LENGTH +: CNT_LENGTH]);
   endtask

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         exp_q.delete();
         m_p = 0; m_k = 0; m_cyc = 0; m_cnt = 0;
         m_max = 0; m_center = 0; m_dead = 0;
         for (int i = 0; i < NUM_CH; i++) begin
            m_duty[i] = 0; m_raw[i] = 1; m_rawq[i] = 0; m_chg_cyc[i] = 0; m_chg_d[i] = 0;
         end
      end else begin
         if (!sys_en) begin
            m_p = 0; m_k = 0; m_cnt = 0; m_done = 1'b0;
            m_pos_e = '0; m_neg_e = '0;
            load_shadows();
            for (int i = 0; i < NUM_CH; i++) begin
               m_rawq[i] = 0; m_chg_d[i] = 0;
               m_raw[i]  = (m_duty[i] == 0) ? 1 : 0;
            end
         end else begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (m_raw[i] != m_rawq[i]) begin
                  m_chg_cyc[i] = m_cyc;
                  m_chg_d[i]   = m_dead;
               end
               if ((m_chg_d[i] != 0) && ((m_cyc - m_chg_cyc[i]) < m_chg_d[i])) begin
                  m_pos_e[i] = 1'b0; m_neg_e[i] = 1'b0;
               end else begin
                  m_pos_e[i] = (m_raw[i] != 0); m_neg_e[i] = (m_raw[i] == 0);
               end
               m_rawq[i] = m_raw[i];
            end
            m_done = 1'b0;
            if ((m_k % (int'(prescale) + 1)) == int'(prescale)) begin
               m_p++;
               if (m_p >= period_len(m_max, m_center)) begin
                  m_p = 0;
                  m_done = 1'b1;
                  load_shadows();
               end
            end
            m_k++;
            m_cnt = cnt_at(m_p, m_max, m_center);
            for (int i = 0; i < NUM_CH; i++) m_raw[i] = (m_cnt >= m_duty[i]) ? 1 : 0;
            m_cyc++;
         end
         exp_q.push_back({m_done, m_neg_e, m_pos_e, CNT_LENGTH'(m_cnt)});
      end
   end

   // ---------------- monitor / scoreboard ----------------
   logic [EW-1:0] mon_e;

   always @(negedge sys_clk) begin
      if (!sys_rst_n) begin
         chk("rst_cnt", int'(cnt_out), 0);
         chk("rst_pos", int'(pwm_pos), 0);
         chk("rst_neg", int'(pwm_neg), 0);
         chk("rst_done", int'(period_done), 0);
      end else if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         chk("cnt", int'(cnt_out), int'(mon_e[CNT_LENGTH-1:0]));
         chk("pos", int'(pwm_pos), int'(mon_e[CNT_LENGTH +: NUM_CH]));
         chk("neg", int'(pwm_neg), int'(mon_e[CNT_LENGTH+NUM_CH +: NUM_CH]));
         chk("done", int'(period_done), int'(mon_e[EW-1]));
         chk("pos_neg_overlap", int'(pwm_pos & pwm_neg), 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pack_duty();
      for (int i = 0; i < NUM_CH; i++) duty_cycle[i*CNT_LENGTH +: CNT_LENGTH] = CNT_LENGTH'(duty_v[i]);
   endtask

   task automatic configure(input int ctr, input int psc, input int mx, input int d0,
                            input int d1, input int d2, input int d3, input int dt);
      @(negedge sys_clk);
      sys_en      = 1'b0;
      center_mode = (ctr != 0);
      prescale    = PSC_W'(psc);
      max_val     = CNT_LENGTH'(mx);
      dead_time   = DT_W'(dt);
      duty_v[0] = d0; duty_v[1] = d1; duty_v[2] = d2; duty_v[3] = d3;
      pack_duty();
      @(negedge sys_clk);
      sys_en = 1'b1;
   endtask

   task automatic count_window(input int cycles, input int ch, output int n_done,
                               output int n_pos, output int n_gap);
      n_done = 0; n_pos = 0; n_gap = 0;
      repeat (cycles) begin
         @(negedge sys_clk);
         n_done += int'(period_done);
         n_pos  += int'(pwm_pos[ch]);
         n_gap  += int'(!pwm_pos[ch] && !pwm_neg[ch]);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(negedge sys_clk);
         n++;
      end while (!period_done && n < 200);
      chk("period_done_timeout", int'(period_done), 1);
   endtask

   task automatic random_inputs();
      int mx;
      mx          = $urandom_range(0, 20);
      center_mode = 1'($urandom_range(0, 1));
      max_val     = CNT_LENGTH'(mx);
      dead_time   = DT_W'($urandom_range(0, 4));
      for (int i = 0; i < NUM_CH; i++) duty_v[i] = $urandom_range(0, mx + 2);
      pack_duty();
   endtask

   // ---------------- stimulus ----------------
   int nd, np, ng, n1, n2, len;

   initial begin
      repeat (3) @(negedge sys_clk);
      #2 sys_rst_n = 1'b1;

      // Edge mode, duty 3 of 10; ch1 duty 0 always high, ch2 duty max+1 always low.
      configure(0, 0, 9, 3, 0, 10, 6, 0);
      repeat (15) @(negedge sys_clk);
      count_window(50, 0, nd, np, ng);
      chk("edge_done_count", nd, 5);
      chk("edge_ch0_high", np, 35);
      chk("edge_ch0_gap", ng, 0);
      count_window(20, 1, nd, np, ng);
      chk("duty0_ch1_high", np, 20);
      count_window(20, 2, nd, np, ng);
      chk("duty_over_max_ch2_high", np, 0);
      chk("duty_over_max_ch2_gap", ng, 0);

      // Center mode, prescale 1: 16-tick period, cnt>=4 for 9 ticks.
      configure(1, 1, 8, 4, 0, 9, 1, 0);
      repeat (20) @(negedge sys_clk);
      count_window(64, 0, nd, np, ng);
      chk("center_done_count", nd, 2);
      chk("center_ch0_high", np, 36);

      // Dead time 3 on a 20-cycle period: two 3-cycle gaps per period.
      configure(0, 0, 19, 10, 5, 15, 0, 3);
      repeat (25) @(negedge sys_clk);
      count_window(40, 0, nd, np, ng);
      chk("dead_ch0_gap", ng, 12);
      chk("dead_ch0_high", np, 14);

      // Shadowed update: mid-period change only applies after the period ends.
      configure(0, 0, 9, 3, 3, 3, 3, 0);
      wait_done(n1);
      repeat (3) @(negedge sys_clk);
      duty_v[0] = 7;
      pack_duty();
      max_val = CNT_LENGTH'(15);
      wait_done(n1);
      chk("shadow_old_period", n1 + 3, 10);
      wait_done(n2);
      chk("shadow_new_period", n2, 16);

      // max_val = 0: an update every tick in both modes.
      configure(0, 2, 0, 0, 1, 2, 3, 1);
      repeat (6) @(negedge sys_clk);
      count_window(30, 0, nd, np, ng);
      chk("max0_edge_done", nd, 10);
      configure(1, 0, 0, 0, 1, 2, 3, 0);
      repeat (4) @(negedge sys_clk);
      count_window(20, 0, nd, np, ng);
      chk("max0_center_done", nd, 20);

      // Randomized segments with occasional mid-period input changes.
      for (int s = 0; s < 8; s++) begin
         @(negedge sys_clk);
         sys_en   = 1'b0;
         prescale = PSC_W'($urandom_range(0, 3));
         random_inputs();
         @(negedge sys_clk);
         sys_en = 1'b1;
         len = $urandom_range(80, 200);
         for (int c = 0; c < len; c++) begin
            @(negedge sys_clk);
            if ($urandom_range(0, 19) == 0) random_inputs();
         end
      end

      // Disable then reset mid-period: outputs clear asynchronously.
      configure(0, 0, 9, 3, 0, 5, 8, 2);
      repeat (13) @(negedge sys_clk);
      sys_en = 1'b0;
      #2 sys_rst_n = 1'b0;
      #1;
      chk("async_rst_cnt", int'(cnt_out), 0);
      chk("async_rst_pos", int'(pwm_pos), 0);
      chk("async_rst_neg", int'(pwm_neg), 0);
      chk("async_rst_done", int'(period_done), 0);
      repeat (2) @(negedge sys_clk);
      #2 sys_rst_n = 1'b1;
      @(negedge sys_clk);
      sys_en = 1'b1;
      #1;
      chk("reenable_cnt_start", int'(cnt_out), 0);
      @(negedge sys_clk);
      chk("reenable_cnt_first_tick", int'(cnt_out), 1);
      repeat (30) @(negedge sys_clk);

      @(negedge sys_clk);
      sys_en = 1'b0;
      repeat (3) @(negedge sys_clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
